// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
//   Shared types and constants for the multi-zone alarm controller.
//   - alarm_state_t : FSM state encoding, also driven out on the state port
//   - DEF_*         : default delays/widths used as parameter defaults
//   - lowest_set()  : index of the lowest set bit of a zone vector
// -----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMING  = 3'd1,
        ARMED   = 3'd2,
        TRIGGER = 3'd3,
        ALERT   = 3'd4
    } alarm_state_t;

    localparam int unsigned MAX_ZONES         = 16;
    localparam int unsigned DEF_CLK_HZ        = 50_000_000;
    localparam int unsigned DEF_NUM_ZONES     = 4;
    localparam int unsigned DEF_DEBOUNCE_CYC  = 1000;
    localparam int unsigned DEF_ARM_DELAY_S   = 10;
    localparam int unsigned DEF_ENTRY_DELAY_S = 15;
    localparam int unsigned DEF_MAX_ATTEMPTS  = 3;
    localparam int unsigned DEF_LOCKOUT_S     = 30;
    localparam int unsigned DEF_TIMER_W       = 8;

    // Returns 0 for an all-zero vector; callers only use it when a bit is set.
    function automatic int unsigned lowest_set(input logic [MAX_ZONES-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_ZONES - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alarm_zone_filter.sv
// -----------------------------------------------------------------------------
// alarm_zone_filter
//   Synchroniser and debouncer for one asynchronous laser trip input.
//   trip_q rises once the synchronised input has been high for DEBOUNCE_CYC
//   consecutive cycles; any low cycle drops it and restarts the count.
// Ports:
//   clock     in  system clock
//   rst       in  asynchronous active-low reset
//   trip_raw  in  raw trip input (asynchronous to clock)
//   trip_q    out debounced trip level
// -----------------------------------------------------------------------------
module alarm_zone_filter #(
    parameter int unsigned DEBOUNCE_CYC = 1000
) (
    input  logic clock,
    input  logic rst,
    input  logic trip_raw,
    output logic trip_q
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples the pre-edge value of the others; blocking here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= trip_raw;
            sync_2 <= sync_1;
            if (!sync_2) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(DEBOUNCE_CYC)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Count saturates at DEBOUNCE_CYC, so the level holds while the input does.
    assign trip_q = (cnt == CNT_W'(DEBOUNCE_CYC));

endmodule

// File: rtl/alarm_zone_controller.sv
// -----------------------------------------------------------------------------
// alarm_zone_controller
//   Multi-zone alarm sequencer: filters NUM_ZONES laser trips, runs the
//   exit-delay / armed / entry-delay / alert sequence, records tripped zones
//   and disarms on passcode verdicts.
//   Optional feature macro: ALARM_LOCKOUT_EN -- wrong-code attempt counter
//   with a timed passcode lockout. Without it locked_out is tied low.
// Ports:
//   clock          in  system clock
//   rst            in  asynchronous active-low reset
//   arm_req        in  1-cycle arm pulse
//   zone_trip      in  raw trip per zone (asynchronous)
//   zone_enable    in  1 = zone monitored
//   code_valid     in  1-cycle passcode verdict strobe
//   code_ok        in  verdict, qualified by code_valid
//   state          out current alarm_state_t
//   seconds_left   out active countdown, else 0
//   tripped_zones  out sticky trip record since last accepted arm
//   first_zone     out lowest-index zone of the trip that entered TRIGGER
//   siren          out high only in ALERT
//   arm_fault      out 1-cycle pulse: arm refused because a zone is tripped
//   locked_out     out passcode entry locked
// -----------------------------------------------------------------------------
module alarm_zone_controller
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
    parameter int unsigned NUM_ZONES     = DEF_NUM_ZONES,
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned ARM_DELAY_S   = DEF_ARM_DELAY_S,
    parameter int unsigned ENTRY_DELAY_S = DEF_ENTRY_DELAY_S,
    parameter int unsigned MAX_ATTEMPTS  = DEF_MAX_ATTEMPTS,
    parameter int unsigned LOCKOUT_S     = DEF_LOCKOUT_S,
    parameter int unsigned TIMER_W       = DEF_TIMER_W,
    localparam int unsigned ZONE_W       = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 arm_req,
    input  logic [NUM_ZONES-1:0] zone_trip,
    input  logic [NUM_ZONES-1:0] zone_enable,
    input  logic                 code_valid,
    input  logic                 code_ok,
    output alarm_state_t         state,
    output logic [TIMER_W-1:0]   seconds_left,
    output logic [NUM_ZONES-1:0] tripped_zones,
    output logic [ZONE_W-1:0]    first_zone,
    output logic                 siren,
    output logic                 arm_fault,
    output logic                 locked_out
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    // ------------------------------------------------------------------ zones
    logic [NUM_ZONES-1:0] trip_q;
    logic [NUM_ZONES-1:0] trip_en;
    logic [NUM_ZONES-1:0] trip_en_d;
    logic [NUM_ZONES-1:0] trip_rise;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        alarm_zone_filter #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_filter (
            .clock    (clock),
            .rst      (rst),
            .trip_raw (zone_trip[z]),
            .trip_q   (trip_q[z])
        );
    end

    assign trip_en   = trip_q & zone_enable;
    assign trip_rise = trip_en & ~trip_en_d;

    // -------------------------------------------------------------- prescaler
    logic [PRE_W-1:0] presc;
    logic             tick;
    logic             load_cnt;
    logic             lock_start;

    assign tick = (presc == PRE_W'(CLK_HZ - 1));

    // ---------------------------------------------------------- code verdicts
    logic code_good;

    // A lockout suppresses every verdict, so a correct code cannot slip through.
    assign code_good = code_valid & code_ok & ~locked_out;

    // -------------------------------------------------------------------- FSM
    alarm_state_t         state_nxt;
    logic [TIMER_W-1:0]   sl_nxt;
    logic [NUM_ZONES-1:0] tripped_nxt;
    logic [ZONE_W-1:0]    first_nxt;
    logic                 arm_fault_nxt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        sl_nxt        = (tick && seconds_left != '0) ? seconds_left - 1'b1 : seconds_left;
        tripped_nxt   = tripped_zones;
        first_nxt     = first_zone;
        arm_fault_nxt = 1'b0;
        load_cnt      = 1'b0;

        unique case (state)
            IDLE: begin
                sl_nxt = '0;
                if (arm_req) begin
                    if (|trip_en) begin
                        arm_fault_nxt = 1'b1;
                    end else begin
                        state_nxt   = ARMING;
                        sl_nxt      = TIMER_W'(ARM_DELAY_S);
                        load_cnt    = 1'b1;
                        tripped_nxt = '0;
                        first_nxt   = '0;
                    end
                end
            end

            ARMING: begin
                if (code_good) begin
                    state_nxt = IDLE;
                    sl_nxt    = '0;
                end else if (tick && seconds_left == TIMER_W'(1)) begin
                    state_nxt = ARMED;
                end
            end

            ARMED: begin
                sl_nxt = '0;
                if (code_good) begin
                    state_nxt = IDLE;
                end else if (|trip_rise) begin
                    state_nxt   = TRIGGER;
                    sl_nxt      = TIMER_W'(ENTRY_DELAY_S);
                    load_cnt    = 1'b1;
                    tripped_nxt = tripped_zones | trip_en;
                    first_nxt   = ZONE_W'(lowest_set(MAX_ZONES'(trip_rise)));
                end
            end

            TRIGGER: begin
                tripped_nxt = tripped_zones | trip_en;
                if (code_good) begin
                    state_nxt = IDLE;
                    sl_nxt    = '0;
                end else if (locked_out) begin
                    // Nobody can disarm during a lockout, so skip the rest of
                    // the entry delay.
                    state_nxt = ALERT;
                    sl_nxt    = '0;
                end else if (tick && seconds_left == TIMER_W'(1)) begin
                    state_nxt = ALERT;
                end
            end

            ALERT: begin
                sl_nxt      = '0;
                tripped_nxt = tripped_zones | trip_en;
                if (code_good) state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                sl_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            seconds_left  <= '0;
            tripped_zones <= '0;
            first_zone    <= '0;
            arm_fault     <= 1'b0;
            trip_en_d     <= '0;
            presc         <= '0;
        end else begin
            seconds_left  <= sl_nxt;
            tripped_zones <= tripped_nxt;
            first_zone    <= first_nxt;
            arm_fault     <= arm_fault_nxt;
            trip_en_d     <= trip_en;
            // Restart on any countdown load so its first second is full length.
            if (load_cnt || lock_start || tick) presc <= '0;
            else                                presc <= presc + 1'b1;
        end
    end

    assign siren = (state == ALERT);

    // ---------------------------------------------------------------- lockout
`ifdef ALARM_LOCKOUT_EN
    localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);

    logic [ATT_W-1:0]   attempts;
    logic [TIMER_W-1:0] lock_left;
    logic               code_bad;

    // Verdicts are ignored in IDLE, so they neither count nor clear there.
    assign code_bad   = (state != IDLE) && code_valid && !code_ok && !locked_out;
    assign lock_start = code_bad && (attempts >= ATT_W'(MAX_ATTEMPTS - 1));

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            attempts   <= '0;
            lock_left  <= '0;
            locked_out <= 1'b0;
        end else if (locked_out) begin
            if (tick) begin
                if (lock_left == TIMER_W'(1)) begin
                    locked_out <= 1'b0;
                    lock_left  <= '0;
                    attempts   <= '0;
                end else begin
                    lock_left <= lock_left - 1'b1;
                end
            end
        end else if (lock_start) begin
            locked_out <= 1'b1;
            lock_left  <= TIMER_W'(LOCKOUT_S);
            attempts   <= ATT_W'(MAX_ATTEMPTS);
        end else if (code_bad) begin
            attempts <= attempts + 1'b1;
        end else if (code_good && state != IDLE) begin
            attempts <= '0;
        end
    end
`else
    assign lock_start = 1'b0;
    assign locked_out = 1'b0;
`endif

endmodule
